flag_branch_unit: RTL and testbench

- Consumes the 3-bit Z/V/N flag vector and opcode produced by the processor ALU.
- Holds the architectural flag register and applies per-opcode flag-write rules.
- Resolves conditional branches against those flags and issues a one-cycle PC redirect to fetch.
- Sits between EX (ALU) and IF/ID. Contains a branch handshake and a stall state for flag hazards.

---
 rtl/flag_branch_unit.sv | 182 ++++++++++++++++++
 tb/tb_flag_branch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// flag_branch_unit
//   Holds the architectural {Z,V,N} flag register, updated from the ALU by
//   per-opcode write rules. Resolves conditional branches from ID against
//   those flags and issues a one-cycle PC redirect to fetch. A branch that
//   arrives while an older flag-writing instruction is still in flight
//   waits until the ALU retires something or the hazard clears.
//
// Ports
//   clk          in   system clock, all state on rising edge
//   rst_n        in   synchronous active-low reset
//   alu_valid    in   ALU result this cycle belongs to a retiring instruction
//   alu_opcode   in   ALU opcode (ADD SUB XOR RED SLL SRA ROR PADDSB)
//   alu_flags    in   {Z,V,N} produced by the ALU this cycle
//   flag_pend    in   an older flag writer has not yet reached the ALU
//   br_valid     in   branch request from ID
//   br_ready     out  unit accepts a branch this cycle
//   br_cond      in   condition code
//   br_target    in   taken address
//   br_fallthru  in   not-taken address (PC+2)
//   flags_q      out  architectural {Z,V,N}
//   redirect     out  one-cycle pulse: load redirect_pc into PC
//   redirect_pc  out  next PC for the resolved branch
//   br_taken     out  resolved outcome, valid with redirect

module flag_branch_unit #(
  parameter int          PC_W        = 16,
  parameter logic [2:0]  RESET_FLAGS = 3'b000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [2:0]      alu_opcode,
  input  logic [2:0]      alu_flags,
  input  logic            flag_pend,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] br_fallthru,
  output logic [2:0]      flags_q,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            br_taken
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  state_t            r_state;
  state_t            w_nextState;
  logic [2:0]        r_flags;
  logic [2:0]        r_cond;
  logic [PC_W-1:0]   r_target;
  logic [PC_W-1:0]   r_fallthru;
  logic              r_taken;
  logic [PC_W-1:0]   r_redirectPc;

  logic [2:0]        w_effFlags;
  logic [2:0]        w_selCond;
  logic [PC_W-1:0]   w_selTarget;
  logic [PC_W-1:0]   w_selFallthru;
  logic              w_taken;
  logic              w_resolve;
  logic              w_capture;

  // Flags are {Z,V,N}: bit 2 is Z, bit 1 is V, bit 0 is N.
  function automatic logic condMet(input logic [2:0] cond, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (cond)
      3'b000:  condMet = !z;
      3'b001:  condMet = z;
      3'b010:  condMet = !z && !n;
      3'b011:  condMet = n;
      3'b100:  condMet = z || (!z && !n);
      3'b101:  condMet = z || n;
      3'b110:  condMet = v;
      default: condMet = 1'b1;
    endcase
  endfunction

  // Effective flags: the register value with this cycle's ALU write applied,
  // so a branch resolving alongside a flag writer sees the new flags.
  always_comb begin
    w_effFlags = r_flags;
    if (alu_valid) begin
      case (alu_opcode)
        OP_ADD, OP_SUB:                 w_effFlags = alu_flags;
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: w_effFlags = {alu_flags[2], r_flags[1:0]};
        default:                        w_effFlags = r_flags;
      endcase
    end
  end

  // In WAIT the branch comes from the captured copy; otherwise straight from ID.
  always_comb begin
    w_selCond     = (r_state == WAIT) ? r_cond     : br_cond;
    w_selTarget   = (r_state == WAIT) ? r_target   : br_target;
    w_selFallthru = (r_state == WAIT) ? r_fallthru : br_fallthru;
    w_taken       = condMet(w_selCond, w_effFlags);
  end

  // Next-state and handshake logic. Unconditional branches never wait since
  // they do not depend on the flags.
  always_comb begin
    w_nextState = r_state;
    br_ready    = 1'b0;
    w_resolve   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        br_ready = 1'b1;
        if (br_valid) begin
          if (!flag_pend || (br_cond == CC_UNCOND)) begin
            w_resolve   = 1'b1;
            w_nextState = RESP;
          end else begin
            w_capture   = 1'b1;
            w_nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (alu_valid || !flag_pend) begin
          w_resolve   = 1'b1;
          w_nextState = RESP;
        end
      end
      RESP: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State, flag register and the registered branch result. Flag writes go on
  // in every state; branch activity never blocks them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_flags      <= RESET_FLAGS;
      r_cond       <= 3'b000;
      r_target     <= '0;
      r_fallthru   <= '0;
      r_taken      <= 1'b0;
      r_redirectPc <= '0;
    end else begin
      r_state <= w_nextState;
      r_flags <= w_effFlags;
      if (w_capture) begin
        r_cond     <= br_cond;
        r_target   <= br_target;
        r_fallthru <= br_fallthru;
      end
      if (w_resolve) begin
        r_taken      <= w_taken;
        r_redirectPc <= w_taken ? w_selTarget : w_selFallthru;
      end
    end
  end

  assign flags_q     = r_flags;
  assign redirect    = (r_state == RESP);
  assign redirect_pc = r_redirectPc;
  assign br_taken    = r_taken;

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit
//   Directed testbench for flag_branch_unit. Inputs are driven 1 time unit
//   after the rising edge and outputs are sampled at that same point, so each
//   check reflects the state after the edge just passed.

module tb_flag_branch_unit;

  localparam int PC_W = 16;

  logic            clk;
  logic            rst_n;
  logic            alu_valid;
  logic [2:0]      alu_opcode;
  logic [2:0]      alu_flags;
  logic            flag_pend;
  logic            br_valid;
  logic            br_ready;
  logic [2:0]      br_cond;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] br_fallthru;
  logic [2:0]      flags_q;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            br_taken;

  int checkCount;
  int errorCount;

  flag_branch_unit #(
    .PC_W(PC_W),
    .RESET_FLAGS(3'b000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .alu_valid(alu_valid),
    .alu_opcode(alu_opcode),
    .alu_flags(alu_flags),
    .flag_pend(flag_pend),
    .br_valid(br_valid),
    .br_ready(br_ready),
    .br_cond(br_cond),
    .br_target(br_target),
    .br_fallthru(br_fallthru),
    .flags_q(flags_q),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .br_taken(br_taken)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advances one clock and moves to the drive/sample point just after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic setAlu(input logic v, input logic [2:0] op, input logic [2:0] f);
    alu_valid  = v;
    alu_opcode = op;
    alu_flags  = f;
  endtask

  // Issues a hazard-free branch, checks the redirect pulse, then returns to IDLE.
  task automatic doBranch(input string tag, input logic [2:0] cond,
                          input logic [15:0] tgt, input logic [15:0] ft,
                          input logic expTaken);
    br_valid    = 1'b1;
    br_cond     = cond;
    br_target   = tgt;
    br_fallthru = ft;
    applyStimulus();
    br_valid = 1'b0;
    checkOutput({tag, "_redirect"}, {31'd0, redirect}, 32'd1);
    checkOutput({tag, "_taken"}, {31'd0, br_taken}, {31'd0, expTaken});
    checkOutput({tag, "_pc"}, {16'd0, redirect_pc}, {16'd0, expTaken ? tgt : ft});
    applyStimulus();
    checkOutput({tag, "_idle"}, {31'd0, redirect}, 32'd0);
  endtask

  // Expected outcomes for conditions 0..7 with flags {Z,V,N}=001 (N set).
  logic [7:0] takenWithN;

  initial begin
    checkCount  = 0;
    errorCount  = 0;
    takenWithN  = 8'b1010_1001;
    rst_n       = 1'b0;
    flag_pend   = 1'b0;
    br_valid    = 1'b0;
    br_cond     = 3'b000;
    br_target   = '0;
    br_fallthru = '0;
    setAlu(1'b0, 3'b000, 3'b000);

    // Reset state.
    applyStimulus();
    applyStimulus();
    checkOutput("rst_flags", {29'd0, flags_q}, 32'h0);
    checkOutput("rst_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("rst_taken", {31'd0, br_taken}, 32'd0);
    checkOutput("rst_pc", {16'd0, redirect_pc}, 32'h0);
    checkOutput("rst_ready", {31'd0, br_ready}, 32'd1);
    rst_n = 1'b1;

    // ADD writes all flags; XOR writes only Z.
    setAlu(1'b1, 3'b000, 3'b101);
    applyStimulus();
    checkOutput("add_flags", {29'd0, flags_q}, 32'h5);
    setAlu(1'b1, 3'b010, 3'b000);
    applyStimulus();
    checkOutput("xor_flags", {29'd0, flags_q}, 32'h1);

    // Clear flags, then RED must not write; alu_valid=0 must not write.
    setAlu(1'b1, 3'b000, 3'b000);
    applyStimulus();
    setAlu(1'b1, 3'b011, 3'b111);
    applyStimulus();
    checkOutput("red_flags", {29'd0, flags_q}, 32'h0);
    setAlu(1'b0, 3'b000, 3'b111);
    applyStimulus();
    checkOutput("novalid_flags", {29'd0, flags_q}, 32'h0);

    // Same-cycle SUB and EQ branch: branch sees forwarded Z=1.
    setAlu(1'b1, 3'b001, 3'b100);
    br_valid    = 1'b1;
    br_cond     = 3'b001;
    br_target   = 16'h0040;
    br_fallthru = 16'h0012;
    applyStimulus();
    setAlu(1'b0, 3'b000, 3'b000);
    br_valid = 1'b0;
    checkOutput("fwd_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("fwd_taken", {31'd0, br_taken}, 32'd1);
    checkOutput("fwd_pc", {16'd0, redirect_pc}, 32'h0040);
    checkOutput("fwd_flags", {29'd0, flags_q}, 32'h4);
    checkOutput("resp_ready", {31'd0, br_ready}, 32'd0);
    applyStimulus();
    checkOutput("fwd_done", {31'd0, redirect}, 32'd0);
    checkOutput("fwd_ready", {31'd0, br_ready}, 32'd1);

    // Hazard: LT waits while flag_pend=1, released by ADD setting N.
    flag_pend   = 1'b1;
    br_valid    = 1'b1;
    br_cond     = 3'b011;
    br_target   = 16'h0100;
    br_fallthru = 16'h0022;
    applyStimulus();
    br_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("wait%0d_ready", i), {31'd0, br_ready}, 32'd0);
      checkOutput($sformatf("wait%0d_redirect", i), {31'd0, redirect}, 32'd0);
      applyStimulus();
    end
    setAlu(1'b1, 3'b000, 3'b001);
    applyStimulus();
    setAlu(1'b0, 3'b000, 3'b000);
    flag_pend = 1'b0;
    checkOutput("haz_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("haz_taken", {31'd0, br_taken}, 32'd1);
    checkOutput("haz_pc", {16'd0, redirect_pc}, 32'h0100);
    checkOutput("haz_flags", {29'd0, flags_q}, 32'h1);
    applyStimulus();
    checkOutput("haz_done", {31'd0, redirect}, 32'd0);

    // Every condition code against flags 001.
    for (int c = 0; c < 8; c++) begin
      doBranch($sformatf("cc%0d", c), c[2:0], 16'h0200 + 16'(c), 16'h0012,
               takenWithN[c]);
    end

    // OV not taken with V=0: redirect still issued with the fall-through.
    doBranch("ov_nt", 3'b110, 16'h0280, 16'h0012, 1'b0);

    // Unconditional with flag_pend=1 resolves without waiting.
    flag_pend = 1'b1;
    doBranch("uncond_pend", 3'b111, 16'h0300, 16'h0032, 1'b1);
    flag_pend = 1'b0;

    // Same-cycle SUB setting V, branch on OV.
    setAlu(1'b1, 3'b001, 3'b010);
    doBranch("ov_fwd", 3'b110, 16'h0340, 16'h0042, 1'b1);
    setAlu(1'b0, 3'b000, 3'b000);

    // Reset while in WAIT drops the branch with no redirect.
    flag_pend   = 1'b1;
    br_valid    = 1'b1;
    br_cond     = 3'b001;
    br_target   = 16'h0400;
    br_fallthru = 16'h0052;
    applyStimulus();
    br_valid = 1'b0;
    checkOutput("rw_wait_ready", {31'd0, br_ready}, 32'd0);
    rst_n = 1'b0;
    applyStimulus();
    rst_n     = 1'b1;
    flag_pend = 1'b0;
    checkOutput("rw_ready", {31'd0, br_ready}, 32'd1);
    checkOutput("rw_flags", {29'd0, flags_q}, 32'h0);
    checkOutput("rw_redirect", {31'd0, redirect}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("rw_quiet%0d", i), {31'd0, redirect}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
